branch_resolve: RTL and testbench

- Resolves conditional branches and jumps at the end of execute, compares each actual outcome with the prediction that fetch attached, and drives the branch-update interface that fetch consumes: branch_update_valid/taken/mispredicted/unconditional/addr/target.
- Tracks an epoch bit so that wrong-path branches issued after a mispredict are silently dropped.
- Keeps branch and mispredict statistics counters.

---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_cmp.sv | 25 ++
 rtl/branch_resolve.sv | 89 ++++++++
 tb/tb_branch_resolve.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for branch resolution: branch/jump kinds and the helper that
// separates unconditional jumps from conditional branches.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5,
    JAL  = 3'd6,
    JALR = 3'd7
  } br_kind_t;

  function automatic logic is_uncond(input br_kind_t kind);
    return (kind == JAL) || (kind == JALR);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch direction evaluator: purely combinational, zero latency, no flow control.
module branch_cmp
  import branch_pkg::*;
(
  input  br_kind_t    kind,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    case (kind)
      BEQ:       taken = (rs1 == rs2);
      BNE:       taken = (rs1 != rs2);
      BLT:       taken = ($signed(rs1) <  $signed(rs2));
      BGE:       taken = ($signed(rs1) >= $signed(rs2));
      BLTU:      taken = (rs1 <  rs2);
      BGEU:      taken = (rs1 >= rs2);
      JAL, JALR: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves branches/jumps against fetch's prediction and drives the branch-update pulse.
// 1-cycle latency; no backpressure, fetch always consumes the update.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_kind,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [31:0]      in_imm,
  input  logic             in_pred_taken,
  input  logic [31:0]      in_pred_target,
  input  logic             in_epoch,
  output logic             branch_update_valid,
  output logic             branch_update_taken,
  output logic             branch_update_mispredicted,
  output logic             branch_update_unconditional,
  output logic [31:0]      branch_update_addr,
  output logic [31:0]      branch_update_target,
  output logic             cur_epoch,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  br_kind_t    kind;
  logic        taken;
  logic [31:0] br_target;
  logic [31:0] jalr_target;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        mispredicted;
  logic        accept;

  assign kind = br_kind_t'(in_kind);

  branch_cmp u_cmp (
    .kind  (kind),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .taken (taken)
  );

  assign br_target   = in_pc + in_imm;
  assign jalr_target = (in_rs1 + in_imm) & ~32'h1;
  assign target      = (kind == JALR) ? jalr_target : br_target;
  assign next_pc     = taken ? target : (in_pc + 32'd4);

  // A taken prediction is only correct if the predicted target also matches.
  assign mispredicted = (taken != in_pred_taken) || (taken && (target != in_pred_target));

  // Instructions stamped with a stale epoch are wrong-path and vanish silently.
  assign accept = in_valid && (in_epoch == cur_epoch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_update_valid         <= 1'b0;
      branch_update_taken         <= 1'b0;
      branch_update_mispredicted  <= 1'b0;
      branch_update_unconditional <= 1'b0;
      branch_update_addr          <= '0;
      branch_update_target        <= '0;
      cur_epoch                   <= 1'b0;
      branch_count                <= '0;
      mispredict_count            <= '0;
    end else begin
      branch_update_valid <= accept;
      if (accept) begin
        branch_update_taken         <= taken;
        branch_update_mispredicted  <= mispredicted;
        branch_update_unconditional <= is_uncond(kind);
        branch_update_addr          <= in_pc;
        branch_update_target        <= next_pc;
        branch_count                <= branch_count + CNT_W'(1);
        if (mispredicted) begin
          cur_epoch        <= ~cur_epoch;
          mispredict_count <= mispredict_count + CNT_W'(1);
        end
      end
    end
  end

  a_kind_known: assert property (@(posedge clk) disable iff (rst) in_valid |-> !$isunknown(in_kind));

endmodule

// File: tb/tb_branch_resolve.sv
// Directed-vector bench for branch_resolve with hand-computed expectations.
module tb_branch_resolve;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_kind = 3'd0;
  logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0, in_pred_target = '0;
  logic        in_pred_taken = 1'b0, in_epoch = 1'b0;
  logic        upd_valid, upd_taken, upd_mis, upd_unc, cur_epoch;
  logic [31:0] upd_addr, upd_target, branch_count, mispredict_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve #(.CNT_W(32)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .in_valid                    (in_valid),
    .in_kind                     (in_kind),
    .in_pc                       (in_pc),
    .in_rs1                      (in_rs1),
    .in_rs2                      (in_rs2),
    .in_imm                      (in_imm),
    .in_pred_taken               (in_pred_taken),
    .in_pred_target              (in_pred_target),
    .in_epoch                    (in_epoch),
    .branch_update_valid         (upd_valid),
    .branch_update_taken         (upd_taken),
    .branch_update_mispredicted  (upd_mis),
    .branch_update_unconditional (upd_unc),
    .branch_update_addr          (upd_addr),
    .branch_update_target        (upd_target),
    .cur_epoch                   (cur_epoch),
    .branch_count                (branch_count),
    .mispredict_count            (mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present one instruction at the falling edge, then step past the rising edge.
  task automatic issue(input br_kind_t k, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic pt,
                       input logic [31:0] ptgt, input logic ep);
    @(negedge clk);
    in_valid = 1'b1; in_kind = k; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt; in_epoch = ep;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic expect_upd(input string tag, input logic tk, input logic mis, input logic unc,
                            input logic [31:0] addr, input logic [31:0] tgt, input logic ep,
                            input logic [31:0] bc, input logic [31:0] mc);
    check({tag, ".valid"}, 32'(upd_valid), 32'd1);
    check({tag, ".taken"}, 32'(upd_taken), 32'(tk));
    check({tag, ".mis"}, 32'(upd_mis), 32'(mis));
    check({tag, ".unc"}, 32'(upd_unc), 32'(unc));
    check({tag, ".addr"}, upd_addr, addr);
    check({tag, ".target"}, upd_target, tgt);
    check({tag, ".epoch"}, 32'(cur_epoch), 32'(ep));
    check({tag, ".bcnt"}, branch_count, bc);
    check({tag, ".mcnt"}, mispredict_count, mc);
  endtask

  task automatic expect_zero(input string tag);
    check({tag, ".valid"}, 32'(upd_valid), 32'd0);
    check({tag, ".taken"}, 32'(upd_taken), 32'd0);
    check({tag, ".mis"}, 32'(upd_mis), 32'd0);
    check({tag, ".unc"}, 32'(upd_unc), 32'd0);
    check({tag, ".addr"}, upd_addr, 32'd0);
    check({tag, ".target"}, upd_target, 32'd0);
    check({tag, ".epoch"}, 32'(cur_epoch), 32'd0);
    check({tag, ".bcnt"}, branch_count, 32'd0);
    check({tag, ".mcnt"}, mispredict_count, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 expect_zero("reset");
    @(negedge clk) rst = 1'b0;

    issue(BEQ, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120, 1'b0);
    expect_upd("beq_ok", 1, 0, 0, 32'h100, 32'h120, 0, 1, 0);
    idle();
    check("idle.valid", 32'(upd_valid), 32'd0);
    check("idle.target_hold", upd_target, 32'h120);

    issue(BNE, 32'h200, 32'd7, 32'd7, 32'h40, 1'b1, 32'h240, 1'b0);
    expect_upd("bne_mis", 0, 1, 0, 32'h200, 32'h204, 1, 2, 1);

    // Same-epoch instruction right behind the mispredict is wrong-path.
    issue(BLT, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h310, 1'b0);
    check("drop.valid", 32'(upd_valid), 32'd0);
    check("drop.bcnt", branch_count, 32'd2);
    check("drop.mcnt", mispredict_count, 32'd1);
    check("drop.epoch", 32'(cur_epoch), 32'd1);

    issue(BLT, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h310, 1'b1);
    expect_upd("blt_signed", 1, 0, 0, 32'h300, 32'h310, 1, 3, 1);

    issue(BLTU, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b0, 32'h404, 1'b1);
    expect_upd("bltu", 0, 0, 0, 32'h400, 32'h404, 1, 4, 1);
    issue(BGEU, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b1, 32'h520, 1'b1);
    expect_upd("bgeu", 1, 0, 0, 32'h500, 32'h520, 1, 5, 1);
    issue(BGE, 32'h540, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h544, 1'b1);
    expect_upd("bge_signed", 0, 0, 0, 32'h540, 32'h544, 1, 6, 1);

    issue(JALR, 32'h600, 32'h1003, 32'd0, 32'h10, 1'b1, 32'h1012, 1'b1);
    expect_upd("jalr_ok", 1, 0, 1, 32'h600, 32'h1012, 1, 7, 1);
    issue(JALR, 32'h600, 32'h1003, 32'd0, 32'h10, 1'b1, 32'h1010, 1'b1);
    expect_upd("jalr_mis", 1, 1, 1, 32'h600, 32'h1012, 0, 8, 2);

    // Reset lands after the accept is presented but before its capturing edge.
    @(negedge clk);
    in_valid = 1'b1; in_kind = JAL; in_pc = 32'h700; in_imm = 32'h8;
    in_pred_taken = 1'b0; in_pred_target = 32'h704; in_epoch = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    expect_zero("rst_mid");
    @(negedge clk) begin rst = 1'b0; in_valid = 1'b0; end
    @(posedge clk); #1;
    check("post_rst.valid", 32'(upd_valid), 32'd0);

    issue(JAL, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 1'b1, 32'h4, 1'b0);
    expect_upd("jal_wrap", 1, 0, 1, 32'hFFFF_FFFC, 32'h4, 0, 1, 0);
    issue(BEQ, 32'hFFFF_FFFC, 32'd1, 32'd2, 32'h10, 1'b0, 32'h0, 1'b0);
    expect_upd("pc4_wrap", 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 2, 0);
    idle();
    check("end.valid", 32'(upd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
